gol_speed_ctrl: RTL and testbench
=================================

Name: gol_speed_ctrl

Overview:
- Generation pacer between the video timing source and the GoL engine.
- Takes the per-frame start-of-frame pulse (video_sof) and one user push-button.
- Emits gen_sof, the gated pulse that tells the engine to compute one generation.
- A short press cycles the speed. A long press toggles pause. A short press while paused single-steps one generation.

Parameters:
- DEBOUNCE_CYCLES, 1485000, clk cycles the button level must be stable before it is accepted (20 ms at 74.25 MHz).
- LONG_FRAMES, 45, video frames of continuous hold that count as a long press.
- DEFAULT_SPEED, 0, speed index loaded at reset.
- BTN_ACTIVE_HIGH, 1, 1 = pressed reads 1 on btn_raw; 0 = pressed reads 0.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- video_sof  in  1  one-cycle pulse at the start of each video frame.
- btn_raw  in  1  asynchronous button pin, not synchronised.
- gen_sof  out  1  one-cycle pulse: engine starts one generation.
- speed_idx  out  3  current speed index, 0..NUM_SPEEDS-1.
- frames_per_gen  out  5  divisor for the current speed_idx, from the package table.
- paused  out  1  1 = automatic generations are suppressed.

Behaviour:
- Reset values: gen_sof=0, speed_idx=DEFAULT_SPEED, paused=0. Internal state: step_pending=0, frame_cnt=0, debounced level=released, press FSM=IDLE.
- Reset takes effect asynchronously on assertion at any point, including mid-press or mid-count. Deassertion is used directly; the caller guarantees it is synchronous to clk.
- Input path: btn_raw passes through a 2-FF synchroniser, then polarity-normalise, then gol_debounce.
  - The debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive clks. Any glitch restarts the count.
  - gol_debounce emits one-cycle press_ev (rising edge) and release_ev (falling edge).
- Press FSM, states IDLE, HELD, LONG:
  - IDLE: on press_ev go to HELD and clear hold_frames.
  - HELD: hold_frames increments on each video_sof. When it reaches LONG_FRAMES, emit long_ev and go to LONG; long_ev fires while the button is still held. A release_ev before that emits short_ev and returns to IDLE.
  - LONG: release_ev returns to IDLE with no event.
  - hold_frames saturates and never wraps.
- Events:
  - short_ev while running: speed_idx <= (speed_idx+1) mod NUM_SPEEDS (wraps 7->0) and frame_cnt <= 0.
  - short_ev while paused: step_pending <= 1. Repeated steps do not queue beyond one.
  - long_ev: paused <= ~paused, step_pending <= 0, frame_cnt <= 0.
- Divider, evaluated only in a cycle with video_sof=1:
  - Paused: gen_sof fires iff step_pending=1; step_pending is then cleared.
  - Running: if frame_cnt >= frames_per_gen-1, fire and set frame_cnt <= 0; otherwise frame_cnt <= frame_cnt+1.
- Latency: gen_sof is registered and asserts exactly 1 clk after the qualifying video_sof cycle, for 1 clk. Never two gen_sof without an intervening video_sof.
- Simultaneous events (event in the same cycle as video_sof):
  - The fire decision uses the pre-event speed_idx and paused.
  - For the counter, the event's frame_cnt<=0 overrides the divider's increment.
  - A step requested in that cycle is consumed at the next video_sof, not the current one.
- frames_per_gen is combinational from speed_idx through the package table.
- Divisor 1 fires on every frame.

Decomposition:
- Package gol_pkg holds:
  - NUM_SPEEDS=8 and SPEED_W=3.
  - FPG_W=5.
  - Divisor table SPEED_DIV = {1,2,3,4,6,8,15,30}.
  - Press FSM state enum {ST_IDLE, ST_HELD, ST_LONG}.
- Sub-module gol_debounce contains the synchroniser, stable counter and edge pulses, parameterised by DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4, LONG_FRAMES=3, video_sof every 20 clks):
- Reset, idle button, speed 0 -> gen_sof 1 clk after every video_sof. During rst all outputs are 0 / DEFAULT_SPEED and frames_per_gen=1.
- Button pulses of 2 clks (bounce) -> no events; speed_idx stays 0.
- Eight short presses (held 1 frame each) -> speed_idx 1,2,...,7,0, frames_per_gen 2,3,4,6,8,15,30,1. At speed 2, gen_sof on every 3rd video_sof after the press.
- Hold for 3 frames -> paused=1 at the 3rd video_sof while still held; no further change on release; zero gen_sof over 10 frames.
- While paused:
  - One short press -> exactly one gen_sof, at the next video_sof.
  - Two short presses within the same frame -> still only one.
  - Long press -> paused=0 and the count restarts from frame_cnt=0.
- Assert rst mid-HELD with speed_idx=5 -> immediate return to reset values; the release afterwards produces no event.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared constants, speed divisor table and press-FSM encoding for the GoL generation pacer.
package gol_pkg;

  localparam int NUM_SPEEDS = 8;
  localparam int SPEED_W    = 3;
  localparam int FPG_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } press_state_t;

  // Frames per generation for each speed index (fastest first).
  function automatic logic [FPG_W-1:0] speed_div(input logic [SPEED_W-1:0] idx);
    logic [FPG_W-1:0] div;
    case (idx)
      3'd0:    div = 5'd1;
      3'd1:    div = 5'd2;
      3'd2:    div = 5'd3;
      3'd3:    div = 5'd4;
      3'd4:    div = 5'd6;
      3'd5:    div = 5'd8;
      3'd6:    div = 5'd15;
      default: div = 5'd30;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/gol_debounce.sv
// Button conditioner: 2-FF synchroniser, polarity normalisation, stability counter
// and one-cycle press/release pulses on the debounced level.
module gol_debounce #(
  parameter int DEBOUNCE_CYCLES = 1485000,
  parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_ev,
  output logic release_ev
);

  localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic IDLE_RAW = BTN_ACTIVE_HIGH ? 1'b0 : 1'b1;

  logic             sync_q1;
  logic             sync_q2;
  logic             pressed;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser to one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= IDLE_RAW;
      sync_q2 <= IDLE_RAW;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign pressed = BTN_ACTIVE_HIGH ? sync_q2 : ~sync_q2;

  // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
      press_ev   <= 1'b0;
      release_ev <= 1'b0;
    end else begin
      press_ev   <= 1'b0;
      release_ev <= 1'b0;
      if (pressed != level) begin
        if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level      <= pressed;
          stable_cnt <= '0;
          press_ev   <= pressed;
          release_ev <= ~pressed;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gol_speed_ctrl.sv
// Generation pacer: divides video_sof by the selected speed and lets one button
// cycle the speed (short press), toggle pause (long press) or single-step while paused.
module gol_speed_ctrl
  import gol_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1485000,
  parameter int LONG_FRAMES     = 45,
  parameter int DEFAULT_SPEED   = 0,
  parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               video_sof,
  input  logic               btn_raw,
  output logic               gen_sof,
  output logic [SPEED_W-1:0] speed_idx,
  output logic [FPG_W-1:0]   frames_per_gen,
  output logic               paused
);

  localparam int                HOLD_W    = $clog2(LONG_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_FRAMES - 1);

  logic              press_ev;
  logic              release_ev;
  logic              short_ev;
  logic              long_ev;
  press_state_t      state_q;
  press_state_t      state_d;
  logic [HOLD_W-1:0] hold_frames;
  logic              step_pending;
  logic [FPG_W-1:0]  frame_cnt;

  gol_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_HIGH (BTN_ACTIVE_HIGH)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .press_ev   (press_ev),
    .release_ev (release_ev)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_frames <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && press_ev) begin
        hold_frames <= '0;
      end else if (state_q == ST_HELD && video_sof && hold_frames < HOLD_MAX) begin
        hold_frames <= hold_frames + HOLD_W'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    short_ev = 1'b0;
    long_ev  = 1'b0;
    case (state_q)
      ST_IDLE: if (press_ev) state_d = ST_HELD;
      ST_HELD: begin
        if (release_ev) begin
          short_ev = 1'b1;
          state_d  = ST_IDLE;
        end else if (video_sof && hold_frames == HOLD_LAST) begin
          long_ev = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_LONG: if (release_ev) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign frames_per_gen = speed_div(speed_idx);

  // Button events are applied after the divider so their counter reset wins,
  // while the fire decision still sees the pre-event speed and pause state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_sof      <= 1'b0;
      speed_idx    <= SPEED_W'(DEFAULT_SPEED);
      paused       <= 1'b0;
      step_pending <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      gen_sof <= 1'b0;
      if (video_sof) begin
        if (paused) begin
          if (step_pending) begin
            gen_sof      <= 1'b1;
            step_pending <= 1'b0;
          end
        end else if (frame_cnt >= frames_per_gen - FPG_W'(1)) begin
          gen_sof   <= 1'b1;
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + FPG_W'(1);
        end
      end
      if (short_ev) begin
        if (paused) begin
          step_pending <= 1'b1;
        end else begin
          speed_idx <= (speed_idx == SPEED_W'(NUM_SPEEDS - 1)) ? '0 : speed_idx + SPEED_W'(1);
          frame_cnt <= '0;
        end
      end
      if (long_ev) begin
        paused       <= ~paused;
        step_pending <= 1'b0;
        frame_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gol_speed_ctrl.sv
// Self-checking bench for gol_speed_ctrl: directed plan plus random button activity,
// checked every cycle against a frame/press-level reference model.
module tb_gol_speed_ctrl;

  localparam int DB         = 4;
  localparam int LF         = 3;
  localparam int SOF_PERIOD = 20;
  localparam int DIVS [8]   = '{1, 2, 3, 4, 6, 8, 15, 30};

  logic       clk = 1'b0;
  logic       rst;
  logic       video_sof = 1'b0;
  logic       btn_raw;
  logic       gen_sof;
  logic [2:0] speed_idx;
  logic [4:0] frames_per_gen;
  logic       paused;

  int checks = 0;
  int errors = 0;
  int gen_cnt = 0;
  bit mon_en = 1'b0;

  gol_speed_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_FRAMES     (LF),
    .DEFAULT_SPEED   (0),
    .BTN_ACTIVE_HIGH (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .video_sof      (video_sof),
    .btn_raw        (btn_raw),
    .gen_sof        (gen_sof),
    .speed_idx      (speed_idx),
    .frames_per_gen (frames_per_gen),
    .paused         (paused)
  );

  always #5 clk = ~clk;

  int sof_phase = 0;
  always @(posedge clk) begin
    #1;
    video_sof = (sof_phase == SOF_PERIOD - 1);
    sof_phase = (sof_phase + 1) % SOF_PERIOD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: synchroniser history, disagreement run length, press
  // classification by frames held, and a frames-since-last-generation counter.
  bit s1, s2, db_pressed, ev_press, ev_rel;
  int db_run;
  bit holding, long_done, short_e, long_e;
  int sofs_held;
  int m_speed, frames;
  bit m_paused, m_step, m_gen;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 = 0; s2 = 0; db_pressed = 0; db_run = 0; ev_press = 0; ev_rel = 0;
      holding = 0; long_done = 0; sofs_held = 0;
      m_speed = 0; m_paused = 0; m_step = 0; frames = 0; m_gen = 0;
    end else begin
      short_e = 0;
      long_e  = 0;
      if (!holding) begin
        if (ev_press) begin holding = 1; long_done = 0; sofs_held = 0; end
      end else if (long_done) begin
        if (ev_rel) holding = 0;
      end else if (ev_rel) begin
        short_e = 1;
        holding = 0;
      end else if (video_sof) begin
        sofs_held++;
        if (sofs_held == LF) begin long_e = 1; long_done = 1; end
      end

      m_gen = 0;
      if (video_sof) begin
        if (m_paused) begin
          if (m_step) begin m_gen = 1; m_step = 0; end
        end else begin
          frames++;
          if (frames >= DIVS[m_speed]) begin m_gen = 1; frames = 0; end
        end
      end
      if (short_e) begin
        if (m_paused) m_step = 1;
        else begin m_speed = (m_speed + 1) % 8; frames = 0; end
      end
      if (long_e) begin m_paused = !m_paused; m_step = 0; frames = 0; end

      ev_press = 0;
      ev_rel   = 0;
      if (s2 != db_pressed) begin
        db_run++;
        if (db_run == DB) begin
          db_pressed = s2;
          db_run     = 0;
          if (db_pressed) ev_press = 1; else ev_rel = 1;
        end
      end else begin
        db_run = 0;
      end
      s2 = s1;
      s1 = btn_raw;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("gen_sof", gen_sof, m_gen);
      check("speed_idx", speed_idx, m_speed);
      check("paused", paused, m_paused);
      check("frames_per_gen", frames_per_gen, DIVS[m_speed]);
      if (gen_sof === 1'b1) gen_cnt++;
    end
  end

  task automatic short_press();
    btn_raw = 1'b1;
    tick(SOF_PERIOD);
    btn_raw = 1'b0;
    tick(SOF_PERIOD);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    rst     = 1'b1;
    btn_raw = 1'b0;
    tick(3);
    mon_en = 1'b1;
    check("rst_gen_sof", gen_sof, 0);
    check("rst_speed", speed_idx, 0);
    check("rst_paused", paused, 0);
    check("rst_fpg", frames_per_gen, 1);
    tick(1);
    rst = 1'b0;

    // Speed 0: one generation per frame.
    tick(5);
    gen_cnt = 0;
    tick(5 * SOF_PERIOD);
    check("speed0_gens", gen_cnt, 5);

    // Short glitches must be filtered.
    repeat (6) begin
      btn_raw = 1'b1; tick(2);
      btn_raw = 1'b0; tick(3);
    end
    tick(SOF_PERIOD);
    check("bounce_speed", speed_idx, 0);

    // Eight short presses walk the whole table and wrap.
    for (int i = 0; i < 8; i++) begin
      short_press();
      check("press_speed", speed_idx, (i + 1) % 8);
      check("press_fpg", frames_per_gen, DIVS[(i + 1) % 8]);
      if (i == 1) begin
        gen_cnt = 0;
        tick(9 * SOF_PERIOD);
        check("speed2_gens", gen_cnt, 3);
      end
    end

    // Long press pauses while still held; release changes nothing.
    btn_raw = 1'b1;
    tick(75);
    check("long_paused_held", paused, 1);
    btn_raw = 1'b0;
    tick(SOF_PERIOD);
    check("long_paused_released", paused, 1);
    gen_cnt = 0;
    tick(10 * SOF_PERIOD);
    check("paused_no_gens", gen_cnt, 0);

    // Single step while paused.
    gen_cnt = 0;
    short_press();
    tick(3 * SOF_PERIOD);
    check("single_step_gens", gen_cnt, 1);

    // Two steps inside one frame still yield one generation.
    found = 1'b0;
    for (int k = 0; k < SOF_PERIOD + 1 && !found; k++) begin
      if (video_sof === 1'b1) found = 1'b1;
      else tick(1);
    end
    check("sof_align_found", found, 1);
    tick(13);
    gen_cnt = 0;
    btn_raw = 1'b1; tick(5);
    btn_raw = 1'b0; tick(5);
    btn_raw = 1'b1; tick(5);
    btn_raw = 1'b0;
    tick(60);
    check("double_step_gens", gen_cnt, 1);

    // Long press resumes.
    btn_raw = 1'b1;
    tick(75);
    check("unpause", paused, 0);
    btn_raw = 1'b0;
    tick(SOF_PERIOD);

    // Reset in the middle of a held press at speed 5.
    repeat (5) short_press();
    check("speed5", speed_idx, 5);
    btn_raw = 1'b1;
    tick(30);
    #3 rst = 1'b1;
    #1;
    check("midheld_rst_speed", speed_idx, 0);
    check("midheld_rst_paused", paused, 0);
    check("midheld_rst_gen", gen_sof, 0);
    check("midheld_rst_fpg", frames_per_gen, 1);
    btn_raw = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(3 * SOF_PERIOD);
    check("after_rst_speed", speed_idx, 0);
    check("after_rst_paused", paused, 0);

    // Random button activity with occasional resets.
    repeat (60) begin
      btn_raw = 1'($urandom_range(0, 1));
      tick(int'($urandom_range(1, 90)));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
    end
    btn_raw = 1'b0;
    tick(5 * SOF_PERIOD);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
